// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings used by the execute stage.
// Covers icodes, condition ifuns, ALU ops, the no-register ID and CC bit positions.
package y86_pkg;
  localparam logic [3:0] CMOVXX = 4'd2;
  localparam logic [3:0] OPq    = 4'd6;
  localparam logic [3:0] JXX    = 4'd7;

  localparam logic [3:0] C_YES = 4'd0;
  localparam logic [3:0] C_LE  = 4'd1;
  localparam logic [3:0] C_L   = 4'd2;
  localparam logic [3:0] C_E   = 4'd3;
  localparam logic [3:0] C_NE  = 4'd4;
  localparam logic [3:0] C_GE  = 4'd5;
  localparam logic [3:0] C_G   = 4'd6;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_XOR = 4'd3;

  localparam logic [3:0] RNONE = 4'hF;

  localparam int CC_ZF = 2;
  localparam int CC_SF = 1;
  localparam int CC_OF = 0;
endpackage

// File: rtl/cond_eval.sv
// Jump / conditional-move condition decode from the registered {ZF,SF,OF}.
module cond_eval
  import y86_pkg::*;
(
  input  logic [2:0] cc,
  input  logic [3:0] ifun,
  output logic       cnd
);
  logic zf, sf, of;

  assign zf = cc[CC_ZF];
  assign sf = cc[CC_SF];
  assign of = cc[CC_OF];

  always_comb begin
    cnd = 1'b0;
    case (ifun)
      C_YES:   cnd = 1'b1;
      C_LE:    cnd = (sf ^ of) | zf;
      C_L:     cnd = sf ^ of;
      C_E:     cnd = zf;
      C_NE:    cnd = ~zf;
      C_GE:    cnd = ~(sf ^ of);
      C_G:     cnd = ~(sf ^ of) & ~zf;
      default: cnd = 1'b0;
    endcase
  end
endmodule

// File: rtl/exec_cc_stage.sv
// Execute-stage result sink: condition codes, jump/cmov condition, E->M register.
// Build option CMOV_CANCEL_EN: a failed CMOVXX loads RNONE as destination here.
module exec_cc_stage
  import y86_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int REG_W  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     e_valid,
  input  logic [3:0]               e_icode,
  input  logic [3:0]               e_ifun,
  input  logic [REG_W-1:0]         e_dstE,
  input  logic signed [DATA_W-1:0] alu_out,
  input  logic                     alu_ovf,
  input  logic                     set_cc_ok,
  input  logic                     m_stall,
  input  logic                     m_bubble,
  output logic                     e_cnd,
  output logic [2:0]               cc,
  output logic                     m_valid,
  output logic signed [DATA_W-1:0] m_valE,
  output logic [REG_W-1:0]         m_dstE,
  output logic                     m_cnd
);
  localparam logic [REG_W-1:0] REG_NONE = {REG_W{1'b1}};

  function automatic logic [2:0] calc_flags(input logic signed [DATA_W-1:0] res,
                                            input logic ovf,
                                            input logic [3:0] op);
    logic [2:0] f;
    f        = 3'b000;
    f[CC_ZF] = (res == '0);
    f[CC_SF] = res[DATA_W-1];
    f[CC_OF] = ((op == ALU_ADD) || (op == ALU_SUB)) ? ovf : 1'b0;
    return f;
  endfunction

  logic [2:0]       flags_p0;
  logic             cc_en_p0;
  logic             cnd_raw_p0;
  logic             is_branch_p0;
  logic [REG_W-1:0] dst_p0;

  assign flags_p0     = calc_flags(alu_out, alu_ovf, e_ifun);
  assign cc_en_p0     = e_valid & (e_icode == OPq) & set_cc_ok & ~m_stall;
  assign is_branch_p0 = (e_icode == JXX) || (e_icode == CMOVXX);

  cond_eval u_cond_eval (
    .cc   (cc),
    .ifun (e_ifun),
    .cnd  (cnd_raw_p0)
  );

  assign e_cnd = e_valid & is_branch_p0 & cnd_raw_p0;

`ifdef CMOV_CANCEL_EN
  assign dst_p0 = ((e_icode == CMOVXX) && !e_cnd) ? REG_NONE : e_dstE;
`else
  assign dst_p0 = e_dstE;
`endif

  // E -> M boundary: condition codes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cc <= 3'b100;
    end else if (cc_en_p0) begin
      cc <= flags_p0;
    end
  end

  // E -> M boundary: pipeline register, stall beats bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_valE  <= '0;
      m_dstE  <= REG_NONE;
      m_cnd   <= 1'b0;
    end else if (!m_stall) begin
      if (m_bubble) begin
        m_valid <= 1'b0;
        m_valE  <= '0;
        m_dstE  <= REG_NONE;
        m_cnd   <= 1'b0;
      end else begin
        m_valid <= e_valid;
        m_valE  <= alu_out;
        m_dstE  <= dst_p0;
        m_cnd   <= e_cnd;
      end
    end
  end
endmodule

// File: tb/tb_exec_cc_stage.sv
// Self-checking bench for exec_cc_stage: directed table, async reset sequence, random vs model.
module tb_exec_cc_stage;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        e_valid;
  logic [3:0]  e_icode, e_ifun, e_dstE;
  logic [63:0] alu_out;
  logic        alu_ovf, set_cc_ok, m_stall, m_bubble;
  logic        e_cnd;
  logic [2:0]  cc;
  logic        m_valid;
  logic [63:0] m_valE;
  logic [3:0]  m_dstE;
  logic        m_cnd;

  int n_cmp = 0;
  int n_err = 0;

  exec_cc_stage #(.DATA_W(64), .REG_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .e_valid(e_valid), .e_icode(e_icode), .e_ifun(e_ifun),
    .e_dstE(e_dstE), .alu_out(alu_out), .alu_ovf(alu_ovf), .set_cc_ok(set_cc_ok),
    .m_stall(m_stall), .m_bubble(m_bubble), .e_cnd(e_cnd), .cc(cc), .m_valid(m_valid),
    .m_valE(m_valE), .m_dstE(m_dstE), .m_cnd(m_cnd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic v; logic [3:0] ic, ifn, dst; logic [63:0] alu; logic ovf, ok, st, bb;
    logic ecnd; logic [2:0] cc; logic mv; logic [63:0] mve; logic [3:0] dcan, dkeep; logic mc;
  } vec_t;

  function automatic vec_t mk(logic v, logic [3:0] ic, logic [3:0] ifn, logic [3:0] dst,
                              logic [63:0] alu, logic ovf, logic ok, logic st, logic bb,
                              logic ecnd, logic [2:0] ecc, logic mv, logic [63:0] mve,
                              logic [3:0] dcan, logic [3:0] dkeep, logic mc);
    vec_t r;
    r.v = v; r.ic = ic; r.ifn = ifn; r.dst = dst; r.alu = alu; r.ovf = ovf; r.ok = ok;
    r.st = st; r.bb = bb; r.ecnd = ecnd; r.cc = ecc; r.mv = mv; r.mve = mve;
    r.dcan = dcan; r.dkeep = dkeep; r.mc = mc;
    return r;
  endfunction

  function automatic logic cond_ref(logic [2:0] c, logic [3:0] f);
    logic zf, sf, of, lt;
    zf = c[2]; sf = c[1]; of = c[0];
    lt = (sf != of);
    case (f)
      4'd0: return 1'b1;
      4'd1: return lt || zf;
      4'd2: return lt;
      4'd3: return zf;
      4'd4: return !zf;
      4'd5: return !lt;
      4'd6: return !lt && !zf;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] pick_dst(logic [3:0] dcan, logic [3:0] dkeep);
`ifdef CMOV_CANCEL_EN
    return dcan;
`else
    return dkeep;
`endif
  endfunction

  task automatic drive(logic v, logic [3:0] ic, logic [3:0] ifn, logic [3:0] dst,
                       logic [63:0] alu, logic ovf, logic ok, logic st, logic bb);
    e_valid = v; e_icode = ic; e_ifun = ifn; e_dstE = dst; alu_out = alu;
    alu_ovf = ovf; set_cc_ok = ok; m_stall = st; m_bubble = bb;
  endtask

  task automatic chk_m(string tag, logic [2:0] ecc, logic mv, logic [63:0] mve,
                       logic [3:0] md, logic mc);
    chk({tag, ".cc"}, 64'(cc), 64'(ecc));
    chk({tag, ".m_valid"}, 64'(m_valid), 64'(mv));
    chk({tag, ".m_valE"}, m_valE, mve);
    chk({tag, ".m_dstE"}, 64'(m_dstE), 64'(md));
    chk({tag, ".m_cnd"}, 64'(m_cnd), 64'(mc));
  endtask

  vec_t tbl[14];

  logic [2:0]  r_cc;
  logic        r_mv, r_mc, r_cnd;
  logic [63:0] r_mve;
  logic [3:0]  r_md;

  initial begin
    localparam logic [63:0] MSB = 64'h8000_0000_0000_0000;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
    //             v  ic    ifn   dst    alu   ovf ok st bb  cnd cc      mv mve    dcan   dkeep  mc
    tbl[0]  = mk(1, 4'd6, 4'd1, 4'h2, 64'h0,  0, 1, 0, 0, 0, 3'b100, 1, 64'h0,  4'h2, 4'h2, 0);
    tbl[1]  = mk(1, 4'd7, 4'd3, 4'hF, 64'h5,  0, 1, 0, 0, 1, 3'b100, 1, 64'h5,  4'hF, 4'hF, 1);
    tbl[2]  = mk(1, 4'd7, 4'd4, 4'hF, 64'h5,  0, 1, 0, 0, 0, 3'b100, 1, 64'h5,  4'hF, 4'hF, 0);
    tbl[3]  = mk(1, 4'd6, 4'd0, 4'h4, MSB,    1, 1, 0, 0, 0, 3'b011, 1, MSB,    4'h4, 4'h4, 0);
    tbl[4]  = mk(1, 4'd7, 4'd2, 4'hF, 64'h0,  0, 1, 0, 0, 0, 3'b011, 1, 64'h0,  4'hF, 4'hF, 0);
    tbl[5]  = mk(1, 4'd7, 4'd5, 4'hF, 64'h0,  0, 1, 0, 0, 1, 3'b011, 1, 64'h0,  4'hF, 4'hF, 1);
    tbl[6]  = mk(1, 4'd6, 4'd2, 4'h5, ONES,   1, 1, 0, 0, 0, 3'b010, 1, ONES,   4'h5, 4'h5, 0);
    tbl[7]  = mk(1, 4'd6, 4'd1, 4'h6, 64'h0,  0, 0, 0, 0, 0, 3'b010, 1, 64'h0,  4'h6, 4'h6, 0);
    tbl[8]  = mk(1, 4'd2, 4'd3, 4'h3, 64'h33, 0, 1, 0, 0, 0, 3'b010, 1, 64'h33, 4'hF, 4'h3, 0);
    tbl[9]  = mk(1, 4'd6, 4'd0, 4'h7, 64'h7,  0, 1, 1, 1, 0, 3'b010, 1, 64'h33, 4'hF, 4'h3, 0);
    tbl[10] = mk(1, 4'd6, 4'd0, 4'h7, 64'h7,  0, 1, 0, 1, 0, 3'b000, 0, 64'h0,  4'hF, 4'hF, 0);
    tbl[11] = mk(0, 4'd6, 4'd1, 4'h9, 64'h0,  0, 1, 0, 0, 0, 3'b000, 0, 64'h0,  4'h9, 4'h9, 0);
    tbl[12] = mk(1, 4'd2, 4'd0, 4'h8, 64'h44, 0, 1, 0, 0, 1, 3'b000, 1, 64'h44, 4'h8, 4'h8, 1);
    tbl[13] = mk(1, 4'd7, 4'd7, 4'hF, 64'h1,  0, 1, 0, 0, 0, 3'b000, 1, 64'h1,  4'hF, 4'hF, 0);

    rst_n = 1'b0;
    drive(0, 4'd0, 4'd0, 4'h0, 64'h0, 0, 1, 0, 0);
    #12;
    chk_m("reset", 3'b100, 1'b0, 64'h0, 4'hF, 1'b0);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].v, tbl[i].ic, tbl[i].ifn, tbl[i].dst, tbl[i].alu, tbl[i].ovf,
            tbl[i].ok, tbl[i].st, tbl[i].bb);
      #2;
      chk($sformatf("vec%0d.e_cnd", i), 64'(e_cnd), 64'(tbl[i].ecnd));
      @(posedge clk); #1;
      chk_m($sformatf("vec%0d", i), tbl[i].cc, tbl[i].mv, tbl[i].mve,
            pick_dst(tbl[i].dcan, tbl[i].dkeep), tbl[i].mc);
    end

    // asynchronous reset between edges, held across an edge, then a normal load
    drive(1, 4'd6, 4'd0, 4'h2, 64'h10, 0, 1, 0, 0);
    #1 rst_n = 1'b0;
    #1;
    chk_m("async_rst", 3'b100, 1'b0, 64'h0, 4'hF, 1'b0);
    @(posedge clk); #1;
    chk_m("rst_held", 3'b100, 1'b0, 64'h0, 4'hF, 1'b0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    chk_m("post_rst", 3'b000, 1'b1, 64'h10, 4'h2, 1'b0);

    r_cc = 3'b000; r_mv = 1'b1; r_mve = 64'h10; r_md = 4'h2; r_mc = 1'b0;
    for (int n = 0; n < 400; n++) begin
      logic [3:0]  ic, ifn, dst;
      logic [63:0] alu;
      logic        v, ovf, ok, st, bb;
      case ($urandom_range(0, 5))
        0, 1: ic = 4'd6;
        2:    ic = 4'd7;
        3:    ic = 4'd2;
        default: ic = 4'($urandom_range(0, 15));
      endcase
      ifn = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(7, 15)) : 4'($urandom_range(0, 6));
      dst = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 3))
        0: alu = 64'h0;
        1: alu = {$urandom, $urandom} | MSB;
        default: alu = {$urandom, $urandom};
      endcase
      v   = ($urandom_range(0, 7) != 0);
      ovf = $urandom_range(0, 1) != 0;
      ok  = ($urandom_range(0, 5) != 0);
      st  = ($urandom_range(0, 7) == 0);
      bb  = ($urandom_range(0, 7) == 0);
      drive(v, ic, ifn, dst, alu, ovf, ok, st, bb);
      r_cnd = v && (ic == 4'd7 || ic == 4'd2) && cond_ref(r_cc, ifn);
      #2;
      chk($sformatf("rnd%0d.e_cnd", n), 64'(e_cnd), 64'(r_cnd));
      if (!st) begin
        if (v && ic == 4'd6 && ok)
          r_cc = {alu == 64'h0, alu[63], (ifn == 4'd0 || ifn == 4'd1) ? ovf : 1'b0};
        if (bb) begin
          r_mv = 1'b0; r_mve = 64'h0; r_md = 4'hF; r_mc = 1'b0;
        end else begin
          r_mv = v; r_mve = alu; r_mc = r_cnd;
          r_md = dst;
`ifdef CMOV_CANCEL_EN
          if (ic == 4'd2 && !r_cnd) r_md = 4'hF;
`endif
        end
      end
      @(posedge clk); #1;
      chk_m($sformatf("rnd%0d", n), r_cc, r_mv, r_mve, r_md, r_mc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
